// File: rtl/reservation_station_pkg.sv
// Shared constants and opcode encoding for the Tomasulo core slice around the
// reservation station.
package reservation_station_pkg;

  localparam int ROB_SIZE_LOG = 4;
  localparam int OP_SIZE_LOG  = 5;
  localparam int RS_SIZE      = 8;
  localparam int RS_SIZE_LOG  = 3;

  typedef enum logic [OP_SIZE_LOG-1:0] {
    OP_NOP   = 5'd0,
    OP_LUI   = 5'd1,
    OP_AUIPC = 5'd2,
    OP_JAL   = 5'd3,
    OP_JALR  = 5'd4,
    OP_BEQ   = 5'd5,
    OP_BNE   = 5'd6,
    OP_BLT   = 5'd7,
    OP_BGE   = 5'd8,
    OP_LB    = 5'd9,
    OP_LH    = 5'd10,
    OP_LW    = 5'd11,
    OP_SB    = 5'd12,
    OP_SH    = 5'd13,
    OP_SW    = 5'd14,
    OP_ADDI  = 5'd15,
    OP_ADD   = 5'd16,
    OP_SUB   = 5'd17,
    OP_AND   = 5'd18,
    OP_OR    = 5'd19,
    OP_XOR   = 5'd20
  } op_e;

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index priority encoder: reports whether any bit is set and the index
// of the lowest set bit.
module rs_select #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan from the top so the lowest set bit is the last to write idx.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds issued ALU instructions until both operands are
// known, snoops the ALU and load/store CDBs, and dispatches one ready entry per cycle.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE      = reservation_station_pkg::RS_SIZE,
  parameter int ROB_SIZE_LOG = reservation_station_pkg::ROB_SIZE_LOG,
  parameter int OP_SIZE_LOG  = reservation_station_pkg::OP_SIZE_LOG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    issue_enable,
  input  logic [OP_SIZE_LOG-1:0]  issue_op,
  input  logic [31:0]             issue_vj,
  input  logic [31:0]             issue_vk,
  input  logic [ROB_SIZE_LOG-1:0] issue_qj,
  input  logic [ROB_SIZE_LOG-1:0] issue_qk,
  input  logic                    issue_rj,
  input  logic                    issue_rk,
  input  logic [31:0]             issue_imm,
  input  logic [31:0]             issue_pc,
  input  logic [ROB_SIZE_LOG-1:0] issue_robid,
  output logic                    full,
  input  logic                    alu_cdb_valid,
  input  logic [ROB_SIZE_LOG-1:0] alu_cdb_robid,
  input  logic [31:0]             alu_cdb_value,
  input  logic                    lsb_cdb_valid,
  input  logic [ROB_SIZE_LOG-1:0] lsb_cdb_robid,
  input  logic [31:0]             lsb_cdb_value,
  output logic                    alu_valid,
  output logic [OP_SIZE_LOG-1:0]  alu_op,
  output logic [31:0]             alu_vj,
  output logic [31:0]             alu_vk,
  output logic [31:0]             alu_imm,
  output logic [31:0]             alu_pc,
  output logic [ROB_SIZE_LOG-1:0] alu_robid
);

  localparam int IW = $clog2(RS_SIZE);

  // Handshake: issue is a one-way strobe; upstream must hold issue_enable low
  // while full=1 (a request made while full is dropped). alu_valid is a one-cycle
  // strobe with no backpressure; rdy=0 freezes every register including outputs.

  logic [RS_SIZE-1:0]      busy, rj, rk;
  logic [OP_SIZE_LOG-1:0]  op    [RS_SIZE];
  logic [31:0]             vj    [RS_SIZE];
  logic [31:0]             vk    [RS_SIZE];
  logic [31:0]             imm   [RS_SIZE];
  logic [31:0]             pc    [RS_SIZE];
  logic [ROB_SIZE_LOG-1:0] qj    [RS_SIZE];
  logic [ROB_SIZE_LOG-1:0] qk    [RS_SIZE];
  logic [ROB_SIZE_LOG-1:0] robid [RS_SIZE];

  logic          free_found, ready_found;
  logic [IW-1:0] free_idx, ready_idx;
  logic          iss_rj, iss_rk;
  logic [31:0]   iss_vj, iss_vk;

  assign full = &busy;

  rs_select #(.N(RS_SIZE), .W(IW)) u_free_sel (
    .vec   (~busy),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_select #(.N(RS_SIZE), .W(IW)) u_ready_sel (
    .vec   (busy & rj & rk),
    .found (ready_found),
    .idx   (ready_idx)
  );

  // Same-cycle CDB bypass for operands arriving with the issue.
  always_comb begin
    iss_rj = issue_rj;
    iss_vj = issue_vj;
    iss_rk = issue_rk;
    iss_vk = issue_vk;
    if (!issue_rj) begin
      if (alu_cdb_valid && alu_cdb_robid == issue_qj) begin
        iss_rj = 1'b1;
        iss_vj = alu_cdb_value;
      end else if (lsb_cdb_valid && lsb_cdb_robid == issue_qj) begin
        iss_rj = 1'b1;
        iss_vj = lsb_cdb_value;
      end
    end
    if (!issue_rk) begin
      if (alu_cdb_valid && alu_cdb_robid == issue_qk) begin
        iss_rk = 1'b1;
        iss_vk = alu_cdb_value;
      end else if (lsb_cdb_valid && lsb_cdb_robid == issue_qk) begin
        iss_rk = 1'b1;
        iss_vk = lsb_cdb_value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy      <= '0;
      alu_valid <= 1'b0;
      alu_op    <= '0;
      alu_vj    <= '0;
      alu_vk    <= '0;
      alu_imm   <= '0;
      alu_pc    <= '0;
      alu_robid <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy      <= '0;
        alu_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && !rj[i]) begin
            if (alu_cdb_valid && alu_cdb_robid == qj[i]) begin
              vj[i] <= alu_cdb_value;
              rj[i] <= 1'b1;
            end else if (lsb_cdb_valid && lsb_cdb_robid == qj[i]) begin
              vj[i] <= lsb_cdb_value;
              rj[i] <= 1'b1;
            end
          end
          if (busy[i] && !rk[i]) begin
            if (alu_cdb_valid && alu_cdb_robid == qk[i]) begin
              vk[i] <= alu_cdb_value;
              rk[i] <= 1'b1;
            end else if (lsb_cdb_valid && lsb_cdb_robid == qk[i]) begin
              vk[i] <= lsb_cdb_value;
              rk[i] <= 1'b1;
            end
          end
        end

        if (ready_found) begin
          busy[ready_idx] <= 1'b0;
          alu_valid       <= 1'b1;
          alu_op          <= op[ready_idx];
          alu_vj          <= vj[ready_idx];
          alu_vk          <= vk[ready_idx];
          alu_imm         <= imm[ready_idx];
          alu_pc          <= pc[ready_idx];
          alu_robid       <= robid[ready_idx];
        end else begin
          alu_valid <= 1'b0;
        end

        // free_idx is never busy, so it cannot collide with the dispatched slot.
        if (issue_enable && free_found) begin
          busy[free_idx]  <= 1'b1;
          op[free_idx]    <= issue_op;
          vj[free_idx]    <= iss_vj;
          rj[free_idx]    <= iss_rj;
          qj[free_idx]    <= issue_qj;
          vk[free_idx]    <= iss_vk;
          rk[free_idx]    <= iss_rk;
          qk[free_idx]    <= issue_qk;
          imm[free_idx]   <= issue_imm;
          pc[free_idx]    <= issue_pc;
          robid[free_idx] <= issue_robid;
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: a slot-table model checked every cycle
// plus hand-computed expectations from the test plan.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int RW = ROB_SIZE_LOG;
  localparam int OW = OP_SIZE_LOG;
  localparam int N  = RS_SIZE;

  logic          clk, rst, rdy, flush;
  logic          issue_enable;
  logic [OW-1:0] issue_op;
  logic [31:0]   issue_vj, issue_vk, issue_imm, issue_pc;
  logic [RW-1:0] issue_qj, issue_qk, issue_robid;
  logic          issue_rj, issue_rk;
  logic          full;
  logic          alu_cdb_valid, lsb_cdb_valid;
  logic [RW-1:0] alu_cdb_robid, lsb_cdb_robid;
  logic [31:0]   alu_cdb_value, lsb_cdb_value;
  logic          alu_valid;
  logic [OW-1:0] alu_op;
  logic [31:0]   alu_vj, alu_vk, alu_imm, alu_pc;
  logic [RW-1:0] alu_robid;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_enable(issue_enable), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_rj(issue_rj), .issue_rk(issue_rk),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_robid(issue_robid),
    .full(full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_robid(alu_cdb_robid), .alu_cdb_value(alu_cdb_value),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_robid(lsb_cdb_robid), .lsb_cdb_value(lsb_cdb_value),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_vj(alu_vj), .alu_vk(alu_vk),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_robid(alu_robid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  typedef struct {
    bit            busy;
    logic [OW-1:0] op;
    logic [31:0]   vj, vk, imm, pc;
    logic [RW-1:0] qj, qk, robid;
    bit            rj, rk;
  } ent_t;

  ent_t          m_ent [N];
  bit            m_valid;
  logic [OW-1:0] m_op;
  logic [31:0]   m_vj, m_vk, m_imm, m_pc;
  logic [RW-1:0] m_robid;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Returns {ready, value} for an operand after looking at both broadcasts.
  function automatic logic [32:0] snoop(input bit r, input logic [RW-1:0] q, input logic [31:0] v);
    if (r) return {1'b1, v};
    if (alu_cdb_valid && alu_cdb_robid == q) return {1'b1, alu_cdb_value};
    if (lsb_cdb_valid && lsb_cdb_robid == q) return {1'b1, lsb_cdb_value};
    return {1'b0, v};
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < N; i++)
      if (!m_ent[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model_step
    ent_t pre [N];
    int sel, fr;
    logic [32:0] sj, sk;
    if (!rst) begin
      for (int i = 0; i < N; i++) m_ent[i].busy = 1'b0;
      m_valid = 1'b0; m_op = '0; m_vj = '0; m_vk = '0;
      m_imm = '0; m_pc = '0; m_robid = '0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < N; i++) m_ent[i].busy = 1'b0;
        m_valid = 1'b0;
      end else begin
        pre = m_ent;
        sel = -1;
        fr  = -1;
        for (int i = N - 1; i >= 0; i--) begin
          if (pre[i].busy && pre[i].rj && pre[i].rk) sel = i;
          if (!pre[i].busy) fr = i;
        end
        for (int i = 0; i < N; i++) begin
          if (pre[i].busy) begin
            sj = snoop(pre[i].rj, pre[i].qj, pre[i].vj);
            sk = snoop(pre[i].rk, pre[i].qk, pre[i].vk);
            {m_ent[i].rj, m_ent[i].vj} = sj;
            {m_ent[i].rk, m_ent[i].vk} = sk;
          end
        end
        if (sel >= 0) begin
          m_valid = 1'b1;
          m_op = pre[sel].op; m_vj = pre[sel].vj; m_vk = pre[sel].vk;
          m_imm = pre[sel].imm; m_pc = pre[sel].pc; m_robid = pre[sel].robid;
          m_ent[sel].busy = 1'b0;
        end else begin
          m_valid = 1'b0;
        end
        if (issue_enable && fr >= 0) begin
          m_ent[fr].busy  = 1'b1;
          m_ent[fr].op    = issue_op;
          m_ent[fr].qj    = issue_qj;
          m_ent[fr].qk    = issue_qk;
          m_ent[fr].imm   = issue_imm;
          m_ent[fr].pc    = issue_pc;
          m_ent[fr].robid = issue_robid;
          sj = snoop(issue_rj, issue_qj, issue_vj);
          sk = snoop(issue_rk, issue_qk, issue_vk);
          {m_ent[fr].rj, m_ent[fr].vj} = sj;
          {m_ent[fr].rk, m_ent[fr].vk} = sk;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("mdl_full",  32'(full),      32'(m_full()));
      check("mdl_valid", 32'(alu_valid), 32'(m_valid));
      check("mdl_op",    32'(alu_op),    32'(m_op));
      check("mdl_vj",    alu_vj,         m_vj);
      check("mdl_vk",    alu_vk,         m_vk);
      check("mdl_imm",   alu_imm,        m_imm);
      check("mdl_pc",    alu_pc,         m_pc);
      check("mdl_robid", 32'(alu_robid), 32'(m_robid));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    issue_enable  = 1'b0;
    flush         = 1'b0;
    alu_cdb_valid = 1'b0;
    lsb_cdb_valid = 1'b0;
  endtask

  task automatic issue(input logic [OW-1:0] op, input logic [31:0] vj, input logic [RW-1:0] qj,
                       input logic rj, input logic [31:0] vk, input logic [RW-1:0] qk,
                       input logic rk, input logic [RW-1:0] robid);
    issue_enable = 1'b1;
    issue_op = op; issue_vj = vj; issue_qj = qj; issue_rj = rj;
    issue_vk = vk; issue_qk = qk; issue_rk = rk; issue_robid = robid;
    issue_imm = 32'h100 + 32'(robid);
    issue_pc  = 32'h8000 + 32'(robid) * 4;
  endtask

  task automatic alu_cdb(input logic [RW-1:0] tag, input logic [31:0] val);
    alu_cdb_valid = 1'b1; alu_cdb_robid = tag; alu_cdb_value = val;
  endtask

  task automatic lsb_cdb(input logic [RW-1:0] tag, input logic [31:0] val);
    lsb_cdb_valid = 1'b1; lsb_cdb_robid = tag; lsb_cdb_value = val;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- directed stimulus ----------------
  initial begin : main
    rst = 1'b0; rdy = 1'b1;
    idle();
    issue_op = '0; issue_vj = '0; issue_vk = '0; issue_qj = '0; issue_qk = '0;
    issue_rj = 1'b0; issue_rk = 1'b0; issue_imm = '0; issue_pc = '0; issue_robid = '0;
    alu_cdb_robid = '0; alu_cdb_value = '0; lsb_cdb_robid = '0; lsb_cdb_value = '0;

    step();
    chk_en = 1'b1;
    check("rst_valid", 32'(alu_valid), 32'd0);
    check("rst_full",  32'(full),      32'd0);
    check("rst_vj",    alu_vj,         32'd0);
    check("rst_robid", 32'(alu_robid), 32'd0);
    step();
    rst = 1'b1;

    // ADD with both operands ready: dispatch two edges after issue.
    issue(OP_ADD, 32'd3, '0, 1'b1, 32'd4, '0, 1'b1, 4'd5);
    step();
    idle();
    check("t1_full_e",   32'(full),      32'd0);
    check("t1_valid_e",  32'(alu_valid), 32'd0);
    step();
    check("t1_valid",    32'(alu_valid), 32'd1);
    check("t1_vj",       alu_vj,         32'd3);
    check("t1_vk",       alu_vk,         32'd4);
    check("t1_robid",    32'(alu_robid), 32'd5);
    check("t1_full",     32'(full),      32'd0);
    step();
    check("t1_pulse",    32'(alu_valid), 32'd0);

    // Wake-up from ALU CDB two cycles after issue.
    issue(OP_SUB, 32'd0, 4'd2, 1'b0, 32'd7, '0, 1'b1, 4'd3);
    step();
    idle();
    step();
    alu_cdb(4'd2, 32'h10);
    step();
    idle();
    check("t2_no_early", 32'(alu_valid), 32'd0);
    step();
    check("t2_valid",    32'(alu_valid), 32'd1);
    check("t2_vj",       alu_vj,         32'h10);
    check("t2_robid",    32'(alu_robid), 32'd3);

    // Issue bypass from the load/store CDB.
    issue(OP_OR, 32'd1, '0, 1'b1, 32'd0, 4'd6, 1'b0, 4'd9);
    lsb_cdb(4'd6, 32'hAB);
    step();
    idle();
    step();
    check("t3_valid",    32'(alu_valid), 32'd1);
    check("t3_vk",       alu_vk,         32'hAB);
    check("t3_robid",    32'(alu_robid), 32'd9);
    step();

    // Fill all slots waiting on tag 1, then one broadcast drains them in order.
    for (int i = 0; i < N; i++) begin
      issue(OP_XOR, 32'd0, 4'd1, 1'b0, 32'(i), '0, 1'b1, RW'(8 + i));
      step();
    end
    idle();
    check("t4_full",     32'(full),      32'd1);
    issue(OP_ADD, 32'd9, '0, 1'b1, 32'd9, '0, 1'b1, 4'd2);
    step();
    idle();
    check("t4_drop_full", 32'(full),     32'd1);
    check("t4_drop_val", 32'(alu_valid), 32'd0);
    alu_cdb(4'd1, 32'h55);
    step();
    idle();
    check("t4_wake_full", 32'(full),     32'd1);
    for (int i = 0; i < N; i++) begin
      step();
      check("t4_seq_valid", 32'(alu_valid), 32'd1);
      check("t4_seq_robid", 32'(alu_robid), 32'(8 + i));
      check("t4_seq_vj",    alu_vj,         32'h55);
      check("t4_seq_vk",    alu_vk,         32'(i));
      if (i == 0) check("t4_full_drop", 32'(full), 32'd0);
    end
    step();
    check("t4_no_extra", 32'(alu_valid), 32'd0);

    // Flush with four waiting entries and a concurrent issue.
    for (int i = 0; i < 4; i++) begin
      issue(OP_AND, 32'd0, 4'd3, 1'b0, 32'd1, '0, 1'b1, RW'(i));
      step();
    end
    flush = 1'b1;
    issue(OP_ADD, 32'd1, '0, 1'b1, 32'd2, '0, 1'b1, 4'd12);
    step();
    idle();
    check("t5_valid",    32'(alu_valid), 32'd0);
    check("t5_full",     32'(full),      32'd0);
    alu_cdb(4'd3, 32'h77);
    step();
    idle();
    step();
    check("t5_no_disp",  32'(alu_valid), 32'd0);
    step();
    check("t5_no_disp2", 32'(alu_valid), 32'd0);

    // rdy=0 freezes outputs and ignores CDB traffic.
    issue(OP_ADD, 32'd0, 4'd5, 1'b0, 32'd1, '0, 1'b1, 4'd1);
    step();
    issue(OP_ADD, 32'h11, '0, 1'b1, 32'h22, '0, 1'b1, 4'd4);
    step();
    issue(OP_SUB, 32'h33, '0, 1'b1, 32'h44, '0, 1'b1, 4'd6);
    step();
    idle();
    check("t6_pre_valid", 32'(alu_valid), 32'd1);
    check("t6_pre_robid", 32'(alu_robid), 32'd4);
    rdy = 1'b0;
    alu_cdb(4'd5, 32'h99);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_hold_valid", 32'(alu_valid), 32'd1);
      check("t6_hold_robid", 32'(alu_robid), 32'd4);
      check("t6_hold_vj",    alu_vj,         32'h11);
    end
    rdy = 1'b1;
    idle();
    step();
    check("t6_resume_valid", 32'(alu_valid), 32'd1);
    check("t6_resume_robid", 32'(alu_robid), 32'd6);
    check("t6_resume_vj",    alu_vj,         32'h33);
    step();
    check("t6_no_wake",  32'(alu_valid), 32'd0);
    flush = 1'b1;
    step();
    idle();
    step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

Out-of-order reservation station for non-memory instructions in the Tomasulo core. It accepts instructions from the issue stage, holds them until both source operands are available, and snoops both CDBs (ALU and load/store) to wake waiting operands. Each cycle it dispatches at most one ready entry to the ALU. It sits between issue and the ALU. The load/store buffer handles `OP_LB..OP_SW` separately.

## Interface
- `RS_SIZE`, default 8: number of entries; power of two.
- `ROB_SIZE_LOG`, default from `utils.v`: ROB tag width.
- `OP_SIZE_LOG`, default from `utils.v`: opcode width.

- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset; synchronous, active-low.
- `rdy`, in, 1: global ready; when low, all state and outputs hold.
- `flush`, in, 1: ROB misprediction clear.
- `issue_enable`, in, 1: allocate an entry this cycle.
- `issue_op`, in, `OP_SIZE_LOG`: decoded op type.
- `issue_vj`/`issue_vk`, in, 32: operand values.
- `issue_qj`/`issue_qk`, in, `ROB_SIZE_LOG`: producer tags.
- `issue_rj`/`issue_rk`, in, 1: operand ready flags.
- `issue_imm`, in, 32: immediate.
- `issue_pc`, in, 32: instruction PC.
- `issue_robid`, in, `ROB_SIZE_LOG`: destination ROB tag.
- `full`, out, 1: no free entry. Combinational from registered busy bits.
- `alu_cdb_valid`, in, 1 / `alu_cdb_robid`, in, `ROB_SIZE_LOG` / `alu_cdb_value`, in, 32: ALU broadcast.
- `lsb_cdb_valid`, in, 1 / `lsb_cdb_robid`, in, `ROB_SIZE_LOG` / `lsb_cdb_value`, in, 32: load/store broadcast.
- `alu_valid`, out, 1: dispatch strobe (registered).
- `alu_op`, out, `OP_SIZE_LOG` / `alu_vj`, `alu_vk`, `alu_imm`, `alu_pc`, out, 32 / `alu_robid`, out, `ROB_SIZE_LOG`: dispatched instruction.

## Operation
- Entry fields: busy, op, vj, qj, rj, vk, qk, rk, imm, pc, robid.
- Allocation: lowest-index non-busy entry. Upstream must not assert `issue_enable` while `full`=1; if it does, the request is dropped and no entry changes.
- Issue bypass: if an incoming operand has r=0 and its q matches a valid CDB tag in the same cycle, store r=1 with the CDB value.
- Wake-up: for every busy entry, an operand with r=0 whose q equals a valid CDB tag gets v←value, r←1. Both CDBs are checked in parallel. If both CDBs carry the same tag (illegal), the ALU CDB wins.
- Selection: the lowest-index entry with busy & rj & rk, evaluated on registered state.
  - The selected entry's busy bit clears at the edge.
  - Output registers load its fields and `alu_valid`←1. With no ready entry, `alu_valid`←0 and the other outputs hold.
- A slot freed by dispatch becomes allocatable only in the following cycle. Issue and dispatch in the same cycle never target the same slot.
- `flush`=1: all busy bits clear, `alu_valid`←0, any same-cycle issue is dropped. Flush takes priority over issue, wake-up and dispatch.
- Reset (`rst`=0 at an edge): all busy=0, `alu_valid`=0, `alu_op`/`alu_vj`/`alu_vk`/`alu_imm`/`alu_pc`/`alu_robid`=0, `full`=0. Reset overrides `rdy`.

## Timing
- Issue sampled at edge E → entry busy after E.
- If both operands were ready at issue, the entry is selected during cycle E..E+1 and `alu_valid` is high after edge E+1. Minimum issue-to-dispatch latency is 2 edges.
- A CDB wake at edge W → dispatchable earliest at edge W+1.
- `alu_valid` pulses one cycle per dispatch. Back-to-back dispatch of different entries gives consecutive high cycles.
- `full` reflects busy bits after the last edge. Same-cycle frees are not counted.
- `rdy`=0: no update of entries or outputs; CDB values presented in that cycle are not captured.

## Structure
- `utils.v`: `OP_*` codes, `ROB_SIZE_LOG`, `OP_SIZE_LOG`, `RS_SIZE`, `RS_SIZE_LOG`.
- Sub-module `rs_select`: parameterised lowest-index priority encoder (vector in → found flag + index). Instantiate it twice: once for free-slot search, once for ready search.

## Test plan
- Reset then issue ADD (rj=rk=1, vj=3, vk=4, robid=5) → `alu_valid`=1 two edges later with vj=3, vk=4, robid=5; `full`=0 throughout.
- Issue with qj=2, rj=0; two cycles later ALU CDB robid=2, value=0x10 → dispatch on the following edge with vj=0x10.
- Issue with qk=6, rk=0, with LSB CDB robid=6, value=0xAB in the same cycle → captured via bypass; dispatch with vk=0xAB at minimum latency.
- Fill 8 entries, all waiting on tag 1 → `full`=1. Broadcast tag 1 → entries dispatch in index order 0..7 on consecutive cycles; `full` drops after the first dispatch edge.
- 4 busy entries, assert `flush` with a concurrent `issue_enable` → next cycle no busy entries, `alu_valid`=0, no dispatch of the dropped instruction.
- Hold `rdy`=0 for 3 cycles while a ready entry exists → `alu_valid` and all outputs unchanged; dispatch resumes one edge after `rdy` returns.
